inst_loader: RTL

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_pkg.sv | 12 +
 rtl/inst_loader_if.sv | 14 +
 rtl/inst_loader_uart_rx.sv | 83 ++++++++
 rtl/inst_loader.sv | 114 +++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared constants and state types for the instruction loader.
package inst_loader_pkg;
   // Instruction BRAM address width; the BRAM holds 2**INST_SIZE words.
   localparam int          INST_SIZE = 4;
   localparam logic [31:0] MAX_WORDS = 32'd1 << INST_SIZE;

   // Framing FSM of the loader.
   typedef enum logic [1:0] {HDR, DATA, DONE, ERR} ld_state_e;

   // UART receiver FSM.
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/inst_loader_if.sv
// Serial input and BRAM/status outputs of the instruction loader.
interface inst_loader_if;
   import inst_loader_pkg::*;

   logic                 rxd;
   logic [INST_SIZE-1:0] addra;
   logic [31:0]          dina;
   logic                 wea;
   logic                 done;
   logic                 err;

   modport master (output rxd, input addra, dina, wea, done, err);
   modport slave  (input rxd, output addra, dina, wea, done, err);
endinterface

// File: rtl/inst_loader_uart_rx.sv
// 8N1 UART byte receiver: mid-bit sampling, glitch-filtered start,
// one-cycle valid/ferr pulses at the middle of the stop bit.
module uart_rx
   import inst_loader_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   output logic       ferr
);
   localparam int            BIT_CYC   = 2 * CLK_PER_HALF_BIT;
   localparam int            CW        = $clog2(BIT_CYC + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);

   // [1:0] is the synchronizer, [2] is one more stage for edge detection
   logic [2:0]    sync_q;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    sh_q;

   logic rx_s, fall, half_tick, bit_tick;
   assign rx_s      = sync_q[1];
   assign fall      = sync_q[2] & ~sync_q[1];
   assign half_tick = (cnt_q == HALF_LAST);
   assign bit_tick  = (cnt_q == BIT_LAST);

   // Bring the asynchronous line into the clk domain (idle high).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[1:0], rxd};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RX_IDLE;
      else        state_q <= state_d;
   end

   // Next state: a start edge that is high again at half a bit is a glitch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RX_IDLE:  if (fall) state_d = RX_START;
         RX_START: if (half_tick) state_d = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (bit_tick && bit_q == 3'd7) state_d = RX_STOP;
         RX_STOP:  if (bit_tick) state_d = RX_IDLE;
         default:  state_d = RX_IDLE;
      endcase
   end

   // Bit timer, bit index and LSB-first shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         bit_q <= '0;
         sh_q  <= '0;
      end else begin
         if (state_q == RX_IDLE || state_d != state_q || bit_tick)
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + CW'(1);
         if (state_q == RX_DATA && bit_tick) begin
            bit_q <= bit_q + 3'd1;
            sh_q  <= {rx_s, sh_q[7:1]};
         end else if (state_q != RX_DATA) begin
            bit_q <= '0;
         end
      end
   end

   // Outputs: the stop-bit sample decides between a good byte and a framing error.
   always_comb begin
      data  = sh_q;
      valid = (state_q == RX_STOP) && bit_tick && rx_s;
      ferr  = (state_q == RX_STOP) && bit_tick && !rx_s;
   end
endmodule

// File: rtl/inst_loader.sv
// Loads a program over UART into instruction BRAM: a 4-byte little-endian
// word count header followed by that many little-endian 32-bit words.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 434
) (
   input logic         clk,
   input logic         rstn,
   inst_loader_if.slave bus
);
   logic [1:0]           rst_sync_q;
   logic                 rst_n;
   logic [7:0]           rx_data;
   logic                 rx_valid, rx_ferr;

   ld_state_e            state_q, state_d;
   logic [1:0]           byte_cnt_q;
   logic [31:0]          word_q;
   logic [INST_SIZE:0]   n_q;
   logic [INST_SIZE:0]   wcnt_q;
   logic [INST_SIZE-1:0] addra_q;
   logic [31:0]          dina_q;
   logic                 wea_q;

   logic                 word_full, last_wr, accept;
   logic [31:0]          word_nxt;

   // Assert immediately, release two clocks after rstn rises.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rst_sync_q <= '0;
      else       rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .rxd   (bus.rxd),
      .data  (rx_data),
      .valid (rx_valid),
      .ferr  (rx_ferr)
   );

   assign accept    = rx_valid && (state_q == HDR || state_q == DATA);
   assign word_full = rx_valid && (byte_cnt_q == 2'd3);
   assign word_nxt  = {rx_data, word_q[31:8]};
   assign last_wr   = wea_q && ((wcnt_q + (INST_SIZE+1)'(1)) == n_q);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= HDR;
      else        state_q <= state_d;
   end

   // Next state: header decode, end of program, framing errors.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HDR: begin
            if (rx_ferr)                   state_d = ERR;
            else if (word_full) begin
               if (word_nxt == 32'd0)      state_d = DONE;
               else if (word_nxt > MAX_WORDS) state_d = ERR;
               else                        state_d = DATA;
            end
         end
         DATA: begin
            if (rx_ferr)       state_d = ERR;
            else if (last_wr)  state_d = DONE;
         end
         DONE:    if (rx_ferr) state_d = ERR;
         ERR:     state_d = ERR;
         default: state_d = HDR;
      endcase
   end

   // Byte-to-word assembly, word count capture and BRAM write/address sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_q <= '0;
         word_q     <= '0;
         n_q        <= '0;
         wcnt_q     <= '0;
         addra_q    <= '0;
         dina_q     <= '0;
         wea_q      <= 1'b0;
      end else begin
         if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            word_q     <= word_nxt;
         end
         if (state_q == HDR && word_full)
            n_q <= word_nxt[INST_SIZE:0];
         wea_q <= (state_q == DATA) && word_full;
         if (state_q == DATA && word_full)
            dina_q <= word_nxt;
         // Address wraps naturally when the BRAM is filled completely.
         if (wea_q) begin
            addra_q <= addra_q + INST_SIZE'(1);
            wcnt_q  <= wcnt_q + (INST_SIZE+1)'(1);
         end
      end
   end

   // Outputs.
   always_comb begin
      bus.addra = addra_q;
      bus.dina  = dina_q;
      bus.wea   = wea_q;
      bus.done  = (state_q == DONE);
      bus.err   = (state_q == ERR);
   end
endmodule
